// File: rtl/seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   state_e      : sequencer FSM states
//   CLS_*        : instruction class codes (ir[15:12])
//   *_MSB/*_LSB  : instruction field positions
//   JEVAL_CYCLES : length of the jump-evaluation window (settle + sample)
package seq_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    DISPATCH = 2'd1,
    JEVAL    = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [3:0] CLS_JUMP = 4'hF;
  localparam logic [3:0] CLS_HALT = 4'hE;

  localparam int CLS_MSB  = 15;
  localparam int CLS_LSB  = 12;
  localparam int COND_MSB = 11;
  localparam int COND_LSB = 8;
  localparam int OFF_MSB  = 7;
  localparam int OFF_LSB  = 0;

  localparam int JEVAL_CYCLES = 2;
  localparam int JCNT_W       = 2;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC calculation.
//   pc      : current program counter
//   offset  : signed 8-bit branch offset
//   take    : 1 = branch taken (pc+1+sext(offset)), 0 = fall through (pc+1)
//   next_pc : result, modulo 2^ADDR_W
module pc_next_calc #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        offset,
  input  logic              take,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] off_sext;

  always_comb begin
    off_sext = {{(ADDR_W-8){offset[7]}}, offset};
    next_pc  = pc + ADDR_W'(1) + (take ? off_sext : '0);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch and program-counter sequencer.
//   clk, rst_n             : clock, synchronous active-low reset
//   imem_req/addr/ack/rdata: instruction memory fetch handshake
//   op, opn                : condition code (and complement) to the jump decoder
//   jmp_en                 : decoder verdict, sampled in the last JEVAL cycle
//   instr_valid/ready      : execute-stage handshake for non-jump instructions
//   instr_out, instr_pc    : offered instruction and its PC
//   halted                 : sequencer stopped on a HALT instruction
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | request instruction at pc, load ir on ack
// DISPATCH | offer ir to execute, advance pc on accept
// JEVAL    | jump resolution: settle cycle, then sample jmp_en and update pc
// HALT     | stopped until reset
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                INSTR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         op,
  output logic [3:0]         opn,
  input  logic               jmp_en,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                imem_req_q, imem_req_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;
  logic [JCNT_W-1:0]   jcnt_q, jcnt_d;

  logic                take;
  logic [ADDR_W-1:0]   pc_next;
  logic [3:0]          rdata_cls;

  assign rdata_cls = imem_rdata[CLS_MSB:CLS_LSB];

  // jmp_en only matters at the terminal count of the JEVAL down-counter;
  // the earlier cycle gives the decoder time to settle on the new op.
  assign take = (state_q == JEVAL) && (jcnt_q == '0) && jmp_en;

  pc_next_calc #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc      (pc_q),
    .offset  (ir_q[OFF_MSB:OFF_LSB]),
    .take    (take),
    .next_pc (pc_next)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    jcnt_d        = jcnt_q;

    case (state_q)
      FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          if (rdata_cls == CLS_HALT) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else if (rdata_cls == CLS_JUMP) begin
            state_d = JEVAL;
            jcnt_d  = JCNT_W'(JEVAL_CYCLES - 1);
          end else begin
            state_d       = DISPATCH;
            instr_valid_d = 1'b1;
          end
        end else begin
          imem_req_d = 1'b1;
        end
      end

      DISPATCH: begin
        if (instr_valid_q && instr_ready) begin
          pc_d          = pc_next;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end

      JEVAL: begin
        if (jcnt_q == '0) begin
          pc_d    = pc_next;
          state_d = FETCH;
        end else begin
          jcnt_d = jcnt_q - JCNT_W'(1);
        end
      end

      HALT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VEC;
      ir_q          <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      jcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      jcnt_q        <= jcnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign op          = ir_q[COND_MSB:COND_LSB];
  assign opn         = ~ir_q[COND_MSB:COND_LSB];
  assign instr_valid = instr_valid_q;
  assign instr_out   = ir_q;
  assign instr_pc    = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a memory/execute/decoder environment
// driven with randomized delays and verdicts, checked against a PC model.
module tb_pc_sequencer;

  localparam logic [15:0] RV = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic [3:0]  op, opn;
  logic        jmp_en = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_out, instr_pc;
  logic        halted;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] pc_m;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W    (16),
    .INSTR_W   (16),
    .RESET_VEC (RV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .op          (op),
    .opn         (opn),
    .jmp_en      (jmp_en),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one instruction at the model PC: fetch handshake, then either the
  // jump window (js = verdict in settle cycle, jt = verdict in sample cycle),
  // the execute handshake, or the halt check. Updates pc_m from the rules.
  task automatic serve(input logic [15:0] instr, input int ack_dly,
                       input int rdy_dly, input bit js, input bit jt);
    int n;
    logic [3:0] cls;
    cls = instr[15:12];
    n = 0;
    // While req is low, acks and readies are stray and must be ignored.
    while (imem_req !== 1'b1 && n < 40) begin
      imem_ack    = 1'($urandom);
      imem_rdata  = 16'($urandom);
      jmp_en      = 1'($urandom);
      instr_ready = 1'($urandom);
      tick();
      n++;
    end
    imem_ack = 1'b0; jmp_en = 1'b0; instr_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_fail++; $display("FAIL req_timeout got=%b exp=1", imem_req);
    end
    n_checks++;
    if (imem_addr !== pc_m) begin
      n_fail++; $display("FAIL fetch_addr got=%h exp=%h", imem_addr, pc_m);
    end
    for (int i = 0; i < ack_dly; i++) begin
      jmp_en = 1'($urandom);
      tick();
      n_checks++;
      if (imem_req !== 1'b1) begin
        n_fail++; $display("FAIL req_hold got=%b exp=1", imem_req);
      end
    end
    imem_ack = 1'b1; imem_rdata = instr; jmp_en = 1'($urandom);
    tick();
    imem_ack = 1'b0; imem_rdata = 16'($urandom); jmp_en = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL req_drop got=%b exp=0", imem_req);
    end
    n_checks++;
    if (op !== instr[11:8] || opn !== ~instr[11:8]) begin
      n_fail++; $display("FAIL op_opn got=%h/%h exp=%h/%h", op, opn, instr[11:8], ~instr[11:8]);
    end
    if (cls == 4'hF) begin
      jmp_en = js;
      tick();
      n_checks++;
      if (instr_valid !== 1'b0 || op !== instr[11:8] || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL jeval_settle got=v%b op%h req%b exp=v0 op%h req0", instr_valid, op, imem_req, instr[11:8]);
      end
      jmp_en = jt;
      tick();
      jmp_en = 1'b0;
      pc_m = 16'(int'(pc_m) + 1 + (jt ? int'($signed(instr[7:0])) : 0));
    end else if (cls == 4'hE) begin
      n_checks++;
      if (halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_set got=%b exp=1", halted);
      end
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== instr || instr_pc !== pc_m) begin
          n_fail++; $display("FAIL offer got=v%b %h@%h exp=v1 %h@%h", instr_valid, instr_out, instr_pc, instr, pc_m);
        end
        instr_ready = (i == rdy_dly);
        jmp_en = 1'($urandom);
        tick();
      end
      instr_ready = 1'b0; jmp_en = 1'b0;
      n_checks++;
      if (instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL valid_drop got=%b exp=0", instr_valid);
      end
      pc_m = pc_m + 16'd1;
    end
  endtask

  // Steer the PC to a target with taken jumps (each moves -127..+128).
  task automatic goto_pc(input logic [15:0] target);
    int d;
    int guard;
    guard = 0;
    while (pc_m != target && guard < 600) begin
      d = int'($signed(16'(target - pc_m)));
      if (d >= -127 && d <= 128) serve({8'hF5, 8'(d - 1)}, 0, 0, 1'b0, 1'b1);
      else if (d > 0)             serve(16'hF57F, 0, 0, 1'b0, 1'b1);
      else                        serve(16'hF580, 0, 0, 1'b0, 1'b1);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (imem_req !== 1'b0 || op !== 4'h0 || opn !== 4'hF || halted !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got=req%b op%h opn%h h%b v%b exp=req0 op0 opnF h0 v0", imem_req, op, opn, halted, instr_valid);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV) begin
      n_fail++; $display("FAIL reset_release got=req%b addr%h exp=req1 addr%h", imem_req, imem_addr, RV);
    end
    pc_m = RV;
  endtask

  task automatic test_ordinary();
    serve(16'h1234, 3, 2, 1'b0, 1'b0);
  endtask

  task automatic test_jump();
    goto_pc(16'h0200);
    serve(16'hF3FE, 1, 0, 1'b0, 1'b1);   // taken -> 01FF
    n_checks++;
    if (pc_m !== 16'h01FF) begin
      n_fail++; $display("FAIL jump_model got=%h exp=01FF", pc_m);
    end
    serve(16'h5000, 0, 1, 1'b0, 1'b0);   // 01FF -> 0200
    serve(16'hF3FE, 2, 0, 1'b1, 1'b0);   // settle-only verdict -> 0201
  endtask

  task automatic test_wrap();
    goto_pc(16'hFFFF);
    serve(16'hF07F, 0, 0, 1'b0, 1'b1);   // -> 007F
    goto_pc(16'hFFFF);
    serve(16'h0042, 1, 0, 1'b0, 1'b0);   // -> 0000
    serve(16'hF0FF, 0, 0, 1'b0, 1'b1);   // offset -1: self-loop at 0000
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int k = 0; k < 40; k++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hE) w[15:12] = 4'h3;
      if (k % 3 == 0) w[15:12] = 4'hF;
      serve(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_midfetch();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin tick(); n++; end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_abandon got=%b exp=0", imem_req);
    end
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hF3FE;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (op !== 4'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RV) begin
      n_fail++; $display("FAIL late_ack got=op%h v%b req%b addr%h exp=op0 v0 req1 addr%h", op, instr_valid, imem_req, imem_addr, RV);
    end
    pc_m = RV;
    serve(16'h2345, 0, 0, 1'b0, 1'b0);
    // Reset while an instruction is being offered.
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin tick(); n++; end
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    tick();
    imem_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== RV) begin
      n_fail++; $display("FAIL rst_dispatch got=v%b addr%h exp=v0 addr%h", instr_valid, imem_addr, RV);
    end
    pc_m = RV;
  endtask

  task automatic test_halt();
    serve(16'hE000, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      imem_ack = ~imem_ack; imem_rdata = 16'($urandom);
      jmp_en = 1'($urandom); instr_ready = 1'($urandom);
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold got=req%b h%b v%b exp=req0 h1 v0", imem_req, halted, instr_valid);
      end
    end
    imem_ack = 1'b0; jmp_en = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_clear got=%b exp=0", halted);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV) begin
      n_fail++; $display("FAIL halt_restart got=req%b addr%h exp=req1 addr%h", imem_req, imem_addr, RV);
    end
  endtask

  initial begin
    test_reset();
    test_ordinary();
    test_jump();
    test_wrap();
    test_random();
    test_reset_midfetch();
    serve(16'h0ABC, 2, 1, 1'b0, 1'b0);
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction fetch and program-counter sequencer. It drives the jump-condition decoder's op/opn inputs and consumes its jmp_en output.
- Fetches instruction words from instruction memory over a req/ack handshake.
- Resolves jump-class instructions internally, using the decoder verdict to select the next PC.
- Hands all other instructions to the execute stage over a valid/ready handshake.

Parameters:
- ADDR_W, 16, PC and instruction-address width.
- INSTR_W, 16, instruction word width (fixed field layout below; must be ≥16).
- RESET_VEC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction word.
- op  out  4  condition code to the jump decoder.
- opn  out  4  bitwise complement of op.
- jmp_en  in  1  jump verdict from the decoder.
- instr_valid  out  1  non-jump instruction offered to execute.
- instr_ready  in  1  execute accepts.
- instr_out  out  INSTR_W  offered instruction.
- instr_pc  out  ADDR_W  PC of the offered instruction.
- halted  out  1  sequencer stopped.

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled only on a rising clk edge while rst_n=0.
- Instruction fields:
  - ir[15:12] is the class. 4'hF is JUMP, 4'hE is HALT, any other value is ordinary.
  - ir[11:8] is the condition code.
  - ir[7:0] is a signed 8-bit offset.
- Reset values:
  - pc=RESET_VEC, ir=0, state=FETCH.
  - imem_req=0, instr_valid=0, halted=0.
  - op=0, opn=4'hF.
- Registered outputs:
  - op=ir[11:8] and opn=~ir[11:8] in all states. Both change only when ir loads.
  - imem_addr=pc.
- FETCH state:
  - imem_req=1, registered. It rises in the first cycle after entry and holds until the ack cycle.
  - On imem_ack with imem_req=1: ir<=imem_rdata and imem_req drops next cycle.
  - Next state after ack: HALT for class E, JEVAL for class F, DISPATCH otherwise.
  - Zero-wait ack (ack in the first request cycle) is legal.
  - imem_ack while imem_req=0 is ignored.
- DISPATCH state:
  - instr_valid=1, instr_out=ir, instr_pc=pc; these hold stable until the handshake.
  - On instr_valid&instr_ready: pc<=pc+1, instr_valid drops, state goes to FETCH.
  - instr_ready alone is ignored.
- JEVAL state (exactly 2 cycles):
  - Cycle 1 is settle: op is already stable and jmp_en is not sampled. This covers the decoder's gate delay.
  - Cycle 2 end: sample jmp_en.
    - jmp_en=1: pc<=pc+1+sext(ir[7:0]).
    - jmp_en=0: pc<=pc+1.
  - Then go to FETCH.
  - jmp_en is ignored in every other state and cycle.
- HALT state: halted=1, imem_req=0, instr_valid=0. Stays until reset.
- Arithmetic:
  - All PC math is modulo 2^ADDR_W. pc+1 at max address wraps to 0.
  - Negative offsets wrap below 0.
  - An offset of -1 gives a self-loop.
- Reset mid-operation:
  - In-flight fetch is abandoned: imem_req=0 the cycle after the reset edge, and a late ack is ignored once req=0.
  - Offered instruction is dropped: instr_valid=0.
  - PC returns to RESET_VEC.
- Exactly one instruction is in flight; there is no prefetch and no flush logic.

Decomposition:
- seq_pkg package:
  - state enum {FETCH, DISPATCH, JEVAL, HALT}.
  - Class constants CLS_JUMP=4'hF and CLS_HALT=4'hE.
  - Field position constants.
  - JEVAL_CYCLES=2.
- Sub-module pc_next_calc (combinational): inputs pc, offset, take; output next PC.
  - next = take ? pc+1+sext(offset) : pc+1.
- The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset with RESET_VEC=16'h0100, then release:
  - Reset cycle: imem_req=0, op=0, opn=F, halted=0.
  - First cycle after release: imem_req=1, imem_addr=0100.
- Ordinary instr 16'h1234 fetched with a 3-cycle ack delay, instr_ready held low 2 cycles:
  - instr_valid with instr_out=1234 and instr_pc=0100, held stable.
  - After accept: next fetch address is 0101.
- Jump 16'hF3FE at pc=0200:
  - op=3, opn=C.
  - jmp_en=1 in the sample cycle gives next fetch at 01FF.
  - jmp_en=1 only in the settle cycle and 0 at sample gives 0201.
- Jump 16'hF07F at pc=FFFF with jmp_en=1 gives next fetch at 007F (wrap). An ordinary instr at FFFF gives 0000.
- rst_n low during an outstanding fetch, with ack arriving 1 cycle after reset:
  - Ack is ignored and imem_req=0.
  - Fetch restarts at RESET_VEC after release.
- HALT 16'hE000:
  - halted=1 and no further imem_req over 20 cycles, even with imem_ack toggling.
  - Only reset clears halted.
